// File: rtl/fm_arbiter.sv
// Feature-map memory for one conv layer, shared by conv/pool read and write ports
// under round-robin arbitration, with a full-map zeroing sweep between timesteps.
module fm_arbiter #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 9,
  parameter int FM_WIDTH         = 32,
  parameter int FM_HEIGHT        = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*COORD_BITS-1:0]              conv_coord_get,
  input  logic                                 conv_read_req,
  output logic                                 conv_read_ready,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] conv_data_out,
  input  logic [2*COORD_BITS-1:0]              conv_coord_wtr,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] conv_data_in,
  input  logic                                 conv_write_req,
  output logic                                 conv_write_ready,
  input  logic [2*COORD_BITS-1:0]              pool_coord_get,
  input  logic                                 pool_read_req,
  output logic                                 pool_read_ready,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] pool_data_out,
  input  logic [2*COORD_BITS-1:0]              pool_coord_wtr,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] pool_data_in,
  input  logic                                 pool_write_req,
  output logic                                 pool_write_ready,
  input  logic                                 clear_start,
  output logic                                 busy
);
  localparam int DATA_W    = CHANNELS * BITS_PER_CHANNEL;
  localparam int DEPTH     = FM_WIDTH * FM_HEIGHT;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam logic [COORD_BITS:0]  X_LIM     = (COORD_BITS+1)'(FM_WIDTH);
  localparam logic [COORD_BITS:0]  Y_LIM     = (COORD_BITS+1)'(FM_HEIGHT);
  localparam logic [ADDR_BITS-1:0] ROW_PITCH = ADDR_BITS'(FM_WIDTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, CLEAR} state_t;

  state_t                 state_q;
  logic [1:0]             rr_q;
  logic                   clear_pending_q;
  logic [ADDR_BITS-1:0]   clr_cnt_q;
  logic                   rd_pool_q;
  logic                   rd_oor_q;
  logic                   conv_read_ready_q, conv_write_ready_q;
  logic                   pool_read_ready_q, pool_write_ready_q;
  logic [DATA_W-1:0]      conv_data_out_q, pool_data_out_q;
  logic                   busy_q;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DATA_W-1:0]      mem_rdata_q;

  logic [3:0]             req_vec;
  logic [1:0]             cand;
  logic                   grant_valid;
  logic [1:0]             grant_idx;
  logic [2*COORD_BITS-1:0] coord_sel;
  logic [COORD_BITS-1:0]  x_sel, y_sel;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [DATA_W-1:0]      wdata_sel;
  logic                   take_clear;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [DATA_W-1:0]      mem_wdata;

  // A port whose ready is high this cycle is masked so a held req is not served twice.
  assign req_vec = {pool_write_req, pool_read_req, conv_write_req, conv_read_req}
                 & ~{pool_write_ready_q, pool_read_ready_q, conv_write_ready_q, conv_read_ready_q};

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!grant_valid && req_vec[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    coord_sel = conv_coord_get;
      2'd1:    coord_sel = conv_coord_wtr;
      2'd2:    coord_sel = pool_coord_get;
      default: coord_sel = pool_coord_wtr;
    endcase
  end

  assign x_sel      = coord_sel[COORD_BITS-1:0];
  assign y_sel      = coord_sel[2*COORD_BITS-1:COORD_BITS];
  assign in_range   = ({1'b0, x_sel} < X_LIM) && ({1'b0, y_sel} < Y_LIM);
  assign req_addr   = ADDR_BITS'(y_sel) * ROW_PITCH + ADDR_BITS'(x_sel);
  assign wdata_sel  = grant_idx[1] ? pool_data_in : conv_data_in;
  assign take_clear = clear_pending_q | clear_start;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = wdata_sel;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
    end else if (state_q == IDLE && !take_clear && grant_valid && grant_idx[0] && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      rr_q               <= 2'd3;
      clear_pending_q    <= 1'b0;
      clr_cnt_q          <= '0;
      rd_pool_q          <= 1'b0;
      rd_oor_q           <= 1'b0;
      conv_read_ready_q  <= 1'b0;
      conv_write_ready_q <= 1'b0;
      pool_read_ready_q  <= 1'b0;
      pool_write_ready_q <= 1'b0;
      conv_data_out_q    <= '0;
      pool_data_out_q    <= '0;
      busy_q             <= 1'b0;
    end else begin
      conv_read_ready_q  <= 1'b0;
      conv_write_ready_q <= 1'b0;
      pool_read_ready_q  <= 1'b0;
      pool_write_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_clear) begin
            state_q         <= CLEAR;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            busy_q          <= 1'b1;
          end else if (grant_valid) begin
            rr_q <= grant_idx;
            if (grant_idx[0]) begin
              if (grant_idx[1]) pool_write_ready_q <= 1'b1;
              else              conv_write_ready_q <= 1'b1;
            end else begin
              rd_pool_q <= grant_idx[1];
              rd_oor_q  <= !in_range;
              state_q   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (rd_pool_q) begin
            pool_read_ready_q <= 1'b1;
            pool_data_out_q   <= rd_oor_q ? '0 : mem_rdata_q;
          end else begin
            conv_read_ready_q <= 1'b1;
            conv_data_out_q   <= rd_oor_q ? '0 : mem_rdata_q;
          end
          if (clear_start) begin
            clear_pending_q <= 1'b1;
            busy_q          <= 1'b1;
          end
          state_q <= IDLE;
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_BITS'(1);
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_read_ready  = conv_read_ready_q;
  assign conv_write_ready = conv_write_ready_q;
  assign pool_read_ready  = pool_read_ready_q;
  assign pool_write_ready = pool_write_ready_q;
  assign conv_data_out    = conv_data_out_q;
  assign pool_data_out    = pool_data_out_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_fm_arbiter.sv
// Self-checking bench for fm_arbiter: table-driven read/write vectors with a
// read-data scoreboard, plus sequences for round-robin, clear and reset corners.
module tb_fm_arbiter;
  localparam int CB = 8;
  localparam int DW = 36;

  logic clk = 1'b0;
  logic rst;
  logic [2*CB-1:0] conv_coord_get, conv_coord_wtr, pool_coord_get, pool_coord_wtr;
  logic conv_read_req, conv_write_req, pool_read_req, pool_write_req;
  logic conv_read_ready, conv_write_ready, pool_read_ready, pool_write_ready;
  logic [DW-1:0] conv_data_out, pool_data_out, conv_data_in, pool_data_in;
  logic clear_start, busy;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int gnt_q[$];

  typedef struct {
    bit rd;
    bit pool;
    int x;
    int y;
    logic [DW-1:0] d;  // write data for writes, expected data for reads
  } vec_t;
  vec_t vt[17];

  always #5 clk = ~clk;

  fm_arbiter dut (
    .clk(clk), .rst(rst),
    .conv_coord_get(conv_coord_get), .conv_read_req(conv_read_req),
    .conv_read_ready(conv_read_ready), .conv_data_out(conv_data_out),
    .conv_coord_wtr(conv_coord_wtr), .conv_data_in(conv_data_in),
    .conv_write_req(conv_write_req), .conv_write_ready(conv_write_ready),
    .pool_coord_get(pool_coord_get), .pool_read_req(pool_read_req),
    .pool_read_ready(pool_read_ready), .pool_data_out(pool_data_out),
    .pool_coord_wtr(pool_coord_wtr), .pool_data_in(pool_data_in),
    .pool_write_req(pool_write_req), .pool_write_ready(pool_write_ready),
    .clear_start(clear_start), .busy(busy)
  );

  function automatic logic [2*CB-1:0] coord(input int x, input int y);
    return {CB'(y), CB'(x)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {60'd0, conv_read_ready, conv_write_ready, pool_read_ready, pool_write_ready}, 64'd0);
    check({name, "_data"}, {28'd0, conv_data_out}, 64'd0);
    check({name, "_pdata"}, {28'd0, pool_data_out}, 64'd0);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic do_write(input bit pool, input int x, input int y, input logic [DW-1:0] d);
    int lat;
    logic rdy;
    if (pool) begin pool_coord_wtr = coord(x, y); pool_data_in = d; pool_write_req = 1'b1; end
    else      begin conv_coord_wtr = coord(x, y); conv_data_in = d; conv_write_req = 1'b1; end
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = pool ? pool_write_ready : conv_write_ready;
    end
    if (pool) pool_write_req = 1'b0; else conv_write_req = 1'b0;
    check("wr_latency", 64'(lat), 64'd1);
    @(negedge clk);
    check("wr_ready_pulse", {63'd0, pool ? pool_write_ready : conv_write_ready}, 64'd0);
    $display("txn wr %s (%0d,%0d) data=%h lat=%0d", pool ? "pool" : "conv", x, y, d, lat);
  endtask

  task automatic do_read(input bit pool, input int x, input int y, input logic [DW-1:0] exp);
    int lat;
    logic rdy;
    logic [DW-1:0] got;
    exp_q.push_back(exp);
    if (pool) begin pool_coord_get = coord(x, y); pool_read_req = 1'b1; end
    else      begin conv_coord_get = coord(x, y); conv_read_req = 1'b1; end
    lat = 0;
    rdy = 1'b0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = pool ? pool_read_ready : conv_read_ready;
    end
    if (pool) pool_read_req = 1'b0; else conv_read_req = 1'b0;
    got = pool ? pool_data_out : conv_data_out;
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_data", {28'd0, got}, {28'd0, exp_q.pop_front()});
    @(negedge clk);
    check("rd_ready_pulse", {63'd0, pool ? pool_read_ready : conv_read_ready}, 64'd0);
    $display("txn rd %s (%0d,%0d) data=%h lat=%0d", pool ? "pool" : "conv", x, y, got, lat);
  endtask

  initial begin
    int cnt;
    int readies;
    int seen;
    int idle;
    int id;
    logic [3:0] rv;

    rst = 1'b1;
    conv_coord_get = '0; conv_coord_wtr = '0; pool_coord_get = '0; pool_coord_wtr = '0;
    conv_read_req = 1'b0; conv_write_req = 1'b0; pool_read_req = 1'b0; pool_write_req = 1'b0;
    conv_data_in = '0; pool_data_in = '0; clear_start = 1'b0;

    vt[0]  = '{1'b0, 1'b0,  3,  5, 36'h0F0F0F0FF};
    vt[1]  = '{1'b1, 1'b0,  3,  5, 36'h0F0F0F0FF};
    vt[2]  = '{1'b0, 1'b0,  8,  3, 36'h123456789};
    vt[3]  = '{1'b0, 1'b1, 40,  2, 36'hFFFFFFFFF};  // x out of range, aliases onto (8,3)
    vt[4]  = '{1'b1, 1'b1, 40,  2, 36'h000000000};
    vt[5]  = '{1'b1, 1'b0,  8,  3, 36'h123456789};
    vt[6]  = '{1'b0, 1'b1,  0,  0, 36'h000000001};
    vt[7]  = '{1'b0, 1'b1, 31, 31, 36'h800000000};
    vt[8]  = '{1'b1, 1'b0, 31, 31, 36'h800000000};
    vt[9]  = '{1'b1, 1'b1,  0,  0, 36'h000000001};
    vt[10] = '{1'b0, 1'b1,  3,  5, 36'h1FF00FF00};
    vt[11] = '{1'b1, 1'b0,  3,  5, 36'h1FF00FF00};
    vt[12] = '{1'b1, 1'b1,  3, 40, 36'h000000000};
    vt[13] = '{1'b0, 1'b0, 31,  0, 36'h0000000FF};
    vt[14] = '{1'b1, 1'b1, 31,  0, 36'h0000000FF};
    vt[15] = '{1'b0, 1'b0,  0, 31, 36'h000000003};
    vt[16] = '{1'b1, 1'b0,  0, 31, 36'h000000003};

    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (vt[i].rd) do_read(vt[i].pool, vt[i].x, vt[i].y, vt[i].d);
      else          do_write(vt[i].pool, vt[i].x, vt[i].y, vt[i].d);
    end

    // Clear sweep with a conv read waiting; clear must win the same-cycle race.
    conv_coord_get = coord(0, 0);
    conv_read_req = 1'b1;
    clear_start = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    clear_start = 1'b0;
    cnt = 0;
    readies = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      if (conv_read_ready | conv_write_ready | pool_read_ready | pool_write_ready) readies++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 64'(cnt), 64'd1024);
    check("clear_no_ready", 64'(readies), 64'd0);
    cnt = 0;
    while (!conv_read_ready && cnt < 10) begin @(negedge clk); cnt++; end
    check("clear_rd_ready", {63'd0, conv_read_ready}, 64'd1);
    check("clear_rd_data", {28'd0, conv_data_out}, {28'd0, exp_q.pop_front()});
    conv_read_req = 1'b0;
    @(negedge clk);
    $display("txn clear sweep busy_cycles=1024 checked");
    do_read(1'b1, 31, 31, '0);
    do_read(1'b0, 3, 5, '0);

    // clear_start arrives while a read is in RD_WAIT.
    do_write(1'b0, 7, 7, 36'h077);
    conv_coord_get = coord(7, 7);
    conv_read_req = 1'b1;
    exp_q.push_back(36'h077);
    @(negedge clk);
    check("rdwait_no_ready_yet", {63'd0, conv_read_ready}, 64'd0);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    conv_read_req = 1'b0;
    check("rdwait_ready", {63'd0, conv_read_ready}, 64'd1);
    check("rdwait_data", {28'd0, conv_data_out}, {28'd0, exp_q.pop_front()});
    check("rdwait_busy_pending", {63'd0, busy}, 64'd1);
    cnt = 1;
    readies = 0;
    @(negedge clk);
    while (busy && cnt < 2000) begin
      cnt++;
      if (conv_read_ready | conv_write_ready | pool_read_ready | pool_write_ready) readies++;
      @(negedge clk);
    end
    check("pending_busy_cycles", 64'(cnt), 64'd1025);
    check("pending_no_ready", 64'(readies), 64'd0);
    $display("txn clear during RD_WAIT busy_cycles=%0d", cnt);
    do_read(1'b0, 7, 7, '0);

    // Reset during RD_WAIT aborts the read.
    do_write(1'b0, 1, 1, 36'h011);
    do_write(1'b1, 3, 3, 36'h033);
    do_write(1'b1, 5, 6, 36'h056);
    do_read(1'b1, 5, 6, 36'h056);
    pool_coord_get = coord(5, 6);
    pool_read_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    pool_read_req = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    @(negedge clk);
    check_all_zero("abort_after");
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset during RD_WAIT");

    // All four requests held high: expect strict rotation starting at conv_rd.
    conv_coord_get = coord(1, 1);
    conv_coord_wtr = coord(2, 2); conv_data_in = 36'h022;
    pool_coord_get = coord(3, 3);
    pool_coord_wtr = coord(4, 4); pool_data_in = 36'h044;
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 4; p++) gnt_q.push_back(p);
    conv_read_req = 1'b1; conv_write_req = 1'b1; pool_read_req = 1'b1; pool_write_req = 1'b1;
    seen = 0;
    idle = 0;
    while (seen < 12 && idle < 10) begin
      @(negedge clk);
      rv = {pool_write_ready, pool_read_ready, conv_write_ready, conv_read_ready};
      if (rv != 4'd0) begin
        idle = 0;
        check("rr_onehot", 64'($countones(rv)), 64'd1);
        id = rv[0] ? 0 : rv[1] ? 1 : rv[2] ? 2 : 3;
        check("rr_order", 64'(id), 64'(gnt_q.pop_front()));
        if (id == 0) check("rr_conv_data", {28'd0, conv_data_out}, 64'h011);
        if (id == 2) check("rr_pool_data", {28'd0, pool_data_out}, 64'h033);
        $display("txn rr grant port=%0d", id);
        seen++;
      end else begin
        idle++;
      end
    end
    conv_read_req = 1'b0; conv_write_req = 1'b0; pool_read_req = 1'b0; pool_write_req = 1'b0;
    check("rr_grants_seen", 64'(seen), 64'd12);
    @(negedge clk);
    @(negedge clk);
    do_read(1'b1, 5, 6, 36'h056);
    do_read(1'b0, 2, 2, 36'h022);
    do_read(1'b1, 4, 4, 36'h044);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
